// File: rtl/firo_trng_core.sv
// Multi-channel Fibonacci ring-oscillator TRNG. The XOR-combined raw bits pass a
// repetition-count health test and von Neumann debiasing, then are packed into words.
module firo_trng_core #(
  parameter int unsigned         NUM_CH     = 4,
  parameter int unsigned         RING_LEN   = 11,
  parameter logic [RING_LEN-1:0] TAP_MASK   = 11'b01111011110,
  parameter int unsigned         WORD_W     = 32,
  parameter int unsigned         DECIM      = 1,
  parameter int unsigned         WARMUP_CYC = 64,
  parameter int unsigned         RCT_CUTOFF = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              bypass,
  input  logic [NUM_CH-1:0] bypass_bits,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              health_fail,
  output logic              busy
);

  localparam int unsigned         WARM_W    = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
  localparam logic [WARM_W-1:0]   WARM_LAST = WARM_W'(WARMUP_CYC - 1);
  localparam logic [7:0]          DEC_LAST  = 8'(DECIM - 1);
  localparam logic [7:0]          RCT_CUT   = 8'(RCT_CUTOFF);
  localparam int unsigned         BIT_W     = $clog2(WORD_W);
  localparam logic [BIT_W-1:0]    BIT_LAST  = BIT_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    COLLECT,
    HOLD,
    FAIL
  } state_t;

  state_t state, state_n;

  logic [NUM_CH-1:0] ring_out;
  logic [NUM_CH-1:0] sync1, sync2;
  logic              raw_bit;
  logic              ring_run;

  logic [WARM_W-1:0] warm_cnt;
  logic [7:0]        dec_cnt;
  logic [7:0]        rct_cnt;
  logic              prev_raw;
  logic              have_first;
  logic              first_bit;
  logic [BIT_W-1:0]  bit_cnt;

  logic              strobe;
  logic [7:0]        rct_next;
  logic              trip;
  logic              kept;
  logic              word_done;
  logic              handshake;

  // Rings are also held quiet in bypass so their nets settle while bypass bits are sampled.
  assign ring_run = en & ~bypass;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ring
    (* keep = "true" *) logic [RING_LEN-1:0] stg;
    (* keep = "true" *) logic                fb;

    assign fb     = ^(stg & TAP_MASK);
    assign stg[0] = ring_run & fb;
    for (genvar s = 1; s < RING_LEN; s++) begin : g_inv
      assign stg[s] = ~stg[s-1];
    end
    assign ring_out[c] = stg[RING_LEN-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bypass ? bypass_bits : ring_out;
      sync2 <= sync1;
    end
  end

  assign raw_bit = ^sync2;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    strobe    = (state == COLLECT) && (dec_cnt == DEC_LAST);
    rct_next  = 8'd1;
    if (rct_cnt != 8'd0 && raw_bit == prev_raw)
      rct_next = (rct_cnt == 8'hFF) ? rct_cnt : rct_cnt + 8'd1;
    trip      = strobe && (rct_next >= RCT_CUT);
    kept      = strobe && !trip && have_first && (first_bit != raw_bit);
    word_done = kept && (bit_cnt == BIT_LAST);
    handshake = word_valid && word_ready;

    unique case (state)
      IDLE:    if (en) state_n = WARMUP;
      WARMUP:  if (!en) state_n = IDLE;
               else if (warm_cnt == WARM_LAST) state_n = COLLECT;
      COLLECT: if (!en) state_n = IDLE;
               else if (trip) state_n = FAIL;
               else if (word_done) state_n = HOLD;
      HOLD:    if (!en) state_n = IDLE;
               else if (handshake) state_n = COLLECT;
      FAIL:    state_n = FAIL;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      warm_cnt   <= '0;
      dec_cnt    <= '0;
      rct_cnt    <= '0;
      prev_raw   <= 1'b0;
      have_first <= 1'b0;
      first_bit  <= 1'b0;
      bit_cnt    <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
    end else if (state != FAIL) begin
      word_valid <= (state_n == HOLD);
      warm_cnt   <= (state == WARMUP) ? warm_cnt + 1'b1 : '0;
      if (state == COLLECT && state_n == COLLECT)
        dec_cnt <= strobe ? 8'd0 : dec_cnt + 8'd1;
      else
        dec_cnt <= '0;

      if (state_n == IDLE) begin
        rct_cnt    <= '0;
        prev_raw   <= 1'b0;
        have_first <= 1'b0;
        first_bit  <= 1'b0;
        bit_cnt    <= '0;
        word_data  <= '0;
      end else begin
        if (strobe) begin
          prev_raw <= raw_bit;
          rct_cnt  <= rct_next;
        end
        if (strobe && !trip) begin
          if (!have_first) begin
            first_bit  <= raw_bit;
            have_first <= 1'b1;
          end else begin
            have_first <= 1'b0;
          end
        end
        // 10 keeps 1 and 01 keeps 0, so the kept bit is always the first of the pair.
        if (kept) begin
          word_data[bit_cnt] <= first_bit;
          bit_cnt            <= word_done ? '0 : bit_cnt + 1'b1;
        end
        if (state_n == HOLD && state != HOLD)
          have_first <= 1'b0;
        if (state == HOLD && state_n == COLLECT) begin
          word_data <= '0;
          bit_cnt   <= '0;
        end
      end
    end
  end

  assign busy        = (state == WARMUP) || (state == COLLECT);
  assign health_fail = (state == FAIL);

endmodule

// File: tb/tb_firo_trng_core.sv
// Directed bench for firo_trng_core in bypass mode: warmup timing, debiased word
// packing, handshake hold, en drop, reset during a pending word and the health trip.
module tb_firo_trng_core;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned WORD_W = 8;

  logic              clk;
  logic              rst;
  logic              en;
  logic              bypass;
  logic [NUM_CH-1:0] bypass_bits;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic              health_fail;
  logic              busy;

  int n_checks = 0;
  int n_pass   = 0;
  int k        = 0;

  logic [3:0] odd_pat  [4] = '{4'b0001, 4'b0111, 4'b1000, 4'b1011};
  logic [3:0] even_pat [4] = '{4'b0000, 4'b0011, 4'b1111, 4'b0101};

  firo_trng_core #(
    .NUM_CH     (NUM_CH),
    .RING_LEN   (11),
    .TAP_MASK   (11'b01111011110),
    .WORD_W     (WORD_W),
    .DECIM      (1),
    .WARMUP_CYC (4),
    .RCT_CUTOFF (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .bypass      (bypass),
    .bypass_bits (bypass_bits),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .health_fail (health_fail),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: drive bypass bits whose XOR is b; that value is consumed two edges later.
  task automatic step(input logic b);
    @(negedge clk);
    bypass_bits = b ? odd_pat[k % 4] : even_pat[k % 4];
    k++;
    @(posedge clk);
    #1;
  endtask

  // Raw stream written in time order: the MSB of the n-bit field goes first.
  task automatic feed(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) step(v[n-1-i]);
  endtask

  task automatic start_en();
    en = 1'b1;
    step(1'b0);
    check("busy_after_en", busy, 1);
    check("valid_in_warmup", word_valid, 0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0);
      check("busy_warmup", busy, 1);
      check("valid_in_warmup", word_valid, 0);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; bypass = 1'b1; bypass_bits = '0; word_ready = 1'b0;
    step(1'b0);
    step(1'b0);
    check("rst_valid", word_valid, 0);
    check("rst_data", word_data, 0);
    check("rst_hfail", health_fail, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Alternating 1,0 raw bits: every pair is 10, word is all ones.
    start_en();
    feed(64'hAAAA, 16);
    check("alt_no_early_valid", word_valid, 0);
    step(1'b0);
    check("alt_valid_15", word_valid, 0);
    step(1'b0);
    check("alt_valid_16", word_valid, 1);
    check("alt_word", word_data, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      step(i == 9);
      check("hold_valid", word_valid, 1);
      check("hold_data", word_data, 8'hFF);
    end
    word_ready = 1'b1;
    step(1'b0);
    check("hs_valid", word_valid, 0);
    check("hs_data", word_data, 0);
    word_ready = 1'b0;
    feed(64'b10_1010_1010_1010, 14);
    step(1'b0);
    check("alt2_valid_15", word_valid, 0);
    step(1'b0);
    check("alt2_valid_16", word_valid, 1);
    check("alt2_word", word_data, 8'hFF);
    en = 1'b0;
    step(1'b0);
    check("en_drop_hold_valid", word_valid, 0);
    check("en_drop_hold_busy", busy, 0);

    // Mixed pairs: kept 0,1,0,1,1,0,0,1 packed LSB-first.
    start_en();
    feed(64'b01_11_10_00_01_10_10_01_01_10, 20);
    step(1'b0);
    check("mix_valid_early", word_valid, 0);
    step(1'b0);
    check("mix_valid", word_valid, 1);
    check("mix_word", word_data, 8'h9A);
    en = 1'b0;
    step(1'b0);
    check("mix_drop_valid", word_valid, 0);
    check("mix_drop_data", word_data, 0);

    // Five kept ones plus a half pair, then en drops; the next word must not see them.
    start_en();
    feed(64'b10_10_10_10_10, 10);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    en = 1'b0;
    step(1'b0);
    check("mid_drop_busy", busy, 0);
    check("mid_drop_valid", word_valid, 0);
    step(1'b0);
    start_en();
    feed(64'b01_10_01_01_10_10_01_10, 16);
    step(1'b0);
    check("rewarm_valid_early", word_valid, 0);
    step(1'b0);
    check("rewarm_valid", word_valid, 1);
    check("rewarm_word", word_data, 8'hB2);

    // Reset while the word is still pending.
    rst = 1'b1;
    step(1'b0);
    check("rst_pend_valid", word_valid, 0);
    check("rst_pend_data", word_data, 0);
    check("rst_pend_busy", busy, 0);
    check("rst_pend_hfail", health_fail, 0);
    step(1'b0);
    rst = 1'b0;

    // Constant 0 raw stream trips the repetition count on the 32nd strobe.
    start_en();
    for (int i = 0; i < 33; i++) step(1'b0);
    check("rct_hfail_31", health_fail, 0);
    check("rct_busy_31", busy, 1);
    step(1'b0);
    check("rct_hfail_32", health_fail, 1);
    check("rct_valid", word_valid, 0);
    check("rct_busy", busy, 0);
    en = 1'b0;
    step(1'b0);
    check("fail_en0_hfail", health_fail, 1);
    check("fail_en0_busy", busy, 0);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      check("fail_en1_hfail", health_fail, 1);
      check("fail_en1_busy", busy, 0);
      check("fail_en1_valid", word_valid, 0);
    end
    rst = 1'b1;
    en = 1'b0;
    step(1'b0);
    check("fail_rst_hfail", health_fail, 0);
    check("fail_rst_busy", busy, 0);
    rst = 1'b0;
    step(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
